// File: rtl/logic_cmp_arbiter.sv
// Round-robin shared logical-compare unit with a fixed-length run of MAX_OPS grants.
// Optional consumed-cond counter output is enabled by defining LOGIC_CMP_COND_CNT_EN.
module logic_cmp_arbiter #(
    parameter  int WIDTH   = 8,
    parameter  int MAX_OPS = 8,
    localparam int CW      = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic             res_and,
    output logic             res_or,
    output logic             res_eq,
    output logic             res_cond,
    output logic [CW-1:0]    op_count,
    output logic             done,
`ifdef LOGIC_CMP_COND_CNT_EN
    output logic [CW-1:0]    cond_count,
`endif
    input  logic             restart
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic       last_grant_reg;
    logic       slot;
    logic       grant;
    logic       grant_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic       cmp_and;
    logic       cmp_or;
    logic       cmp_eq;
    logic       cmp_cond;
    logic       last_op;
    logic       rearm;

    // A new pair may issue only while running and the result slot is free or being freed.
    assign slot = (!res_valid || res_ready) && (state_reg == ST_RUN);

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (req0_valid && req1_valid) begin
            if (last_grant_reg) begin
                req0_ready = slot;
            end else begin
                req1_ready = slot;
            end
        end else begin
            req0_ready = req0_valid && slot;
            req1_ready = req1_valid && slot;
        end
    end

    assign grant    = req0_ready || req1_ready;
    assign grant_id = req1_ready;
    assign sel_a    = grant_id ? req1_a : req0_a;
    assign sel_b    = grant_id ? req1_b : req0_b;

    assign cmp_and  = (sel_a != '0) && (sel_b != '0);
    assign cmp_or   = (sel_a != '0) || (sel_b != '0);
    assign cmp_eq   = (sel_a == sel_b);
    assign cmp_cond = ((sel_a[3] == sel_b[3]) && (sel_a[2] != sel_b[2])) || (sel_a == '0);

    assign last_op  = (op_count == CW'(MAX_OPS - 1));
    assign rearm    = (state_reg == ST_DONE) && restart;
    assign done     = (state_reg == ST_DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (grant && last_op) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!res_valid || res_ready) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (restart) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_RUN;
            last_grant_reg <= 1'b1;
            op_count       <= '0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                last_grant_reg <= grant_id;
                op_count       <= op_count + 1'b1;
            end else if (rearm) begin
                last_grant_reg <= 1'b1;
                op_count       <= '0;
            end
        end
    end

    // A grant overwrites the result registers; otherwise they hold until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_and   <= 1'b0;
            res_or    <= 1'b0;
            res_eq    <= 1'b0;
            res_cond  <= 1'b0;
        end else if (grant) begin
            res_valid <= 1'b1;
            res_id    <= grant_id;
            res_and   <= cmp_and;
            res_or    <= cmp_or;
            res_eq    <= cmp_eq;
            res_cond  <= cmp_cond;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef LOGIC_CMP_COND_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond_count <= '0;
        end else if (rearm) begin
            cond_count <= '0;
        end else if (res_valid && res_ready && res_cond && (cond_count != CW'(MAX_OPS))) begin
            cond_count <= cond_count + 1'b1;
        end
    end
`else
    // Without the counter the result stream needs no extra bookkeeping.
`endif

endmodule

// File: tb/tb_logic_cmp_arbiter.sv
// Randomized and directed bench for logic_cmp_arbiter against a cycle-level reference model.
module tb_logic_cmp_arbiter;
    localparam int WIDTH   = 8;
    localparam int MAX_OPS = 8;
    localparam int CW      = $clog2(MAX_OPS + 1);

    logic             clk;
    logic             rst;
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;
    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic             res_and;
    logic             res_or;
    logic             res_eq;
    logic             res_cond;
    logic [CW-1:0]    op_count;
    logic             done;
    logic             restart;
`ifdef LOGIC_CMP_COND_CNT_EN
    logic [CW-1:0]    cond_count;
`endif

    logic_cmp_arbiter #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_and    (res_and),
        .res_or     (res_or),
        .res_eq     (res_eq),
        .res_cond   (res_cond),
        .op_count   (op_count),
        .done       (done),
`ifdef LOGIC_CMP_COND_CNT_EN
        .cond_count (cond_count),
`endif
        .restart    (restart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 = running, 1 = draining, 2 = finished.
    int m_valid, m_id, m_and, m_or, m_eq, m_cond;
    int m_count, m_phase, m_last, m_cc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_and = 0; m_or = 0; m_eq = 0; m_cond = 0;
        m_count = 0; m_phase = 0; m_last = 1; m_cc = 0;
    endtask

    function automatic int bit_of(input int v, input int n);
        return (v >> n) & 1;
    endfunction

    function automatic int rand_op();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return int'($urandom_range(0, 15));
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic cycle(input bit v0, input int a0, input int b0,
                         input bit v1, input int a1, input int b1,
                         input bit rr, input bit rs);
        int g;
        int ga, gb;
        bit open;
        req0_valid = v0; req0_a = a0[WIDTH-1:0]; req0_b = b0[WIDTH-1:0];
        req1_valid = v1; req1_a = a1[WIDTH-1:0]; req1_b = b1[WIDTH-1:0];
        res_ready  = rr; restart = rs;
        #2;
        open = ((m_valid == 0) || rr) && (m_phase == 0);
        g = -1;
        if (open) begin
            if (v0 && v1) g = (m_last == 1) ? 0 : 1;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        $display("cycle t=%0t v=%0d%0d rr=%0d rs=%0d grant=%0d count=%0d phase=%0d",
                 $time, v0, v1, rr, rs, g, m_count, m_phase);
        check_val("req0_ready", req0_ready, (g == 0));
        check_val("req1_ready", req1_ready, (g == 1));
        check_val("res_valid", res_valid, m_valid);
        check_val("done", done, (m_phase == 2));
        check_val("op_count", op_count, m_count);
        if (m_valid != 0) begin
            check_val("res_id", res_id, m_id);
            check_val("res_and", res_and, m_and);
            check_val("res_or", res_or, m_or);
            check_val("res_eq", res_eq, m_eq);
            check_val("res_cond", res_cond, m_cond);
        end
`ifdef LOGIC_CMP_COND_CNT_EN
        check_val("cond_count", cond_count, m_cc);
`endif
        @(posedge clk);
        if ((m_valid != 0) && rr && (m_cond != 0) && (m_cc < MAX_OPS)) m_cc++;
        case (m_phase)
            1: if ((m_valid == 0) || rr) m_phase = 2;
            2: if (rs) begin m_phase = 0; m_count = 0; m_last = 1; m_cc = 0; end
            default: ;
        endcase
        if (g >= 0) begin
            ga = (g == 0) ? a0 & 255 : a1 & 255;
            gb = (g == 0) ? b0 & 255 : b1 & 255;
            m_valid = 1;
            m_id    = g;
            m_last  = g;
            m_and   = (ga != 0 && gb != 0) ? 1 : 0;
            m_or    = (ga != 0 || gb != 0) ? 1 : 0;
            m_eq    = (ga == gb) ? 1 : 0;
            m_cond  = ((bit_of(ga, 3) == bit_of(gb, 3) && bit_of(ga, 2) != bit_of(gb, 2)) || ga == 0) ? 1 : 0;
            m_count++;
            if (m_count == MAX_OPS) m_phase = 1;
        end else if (rr) begin
            m_valid = 0;
        end
        #1;
    endtask

    initial begin
        int a, b;
        int steps;
        rst = 1'b1;
        req0_valid = 0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0;
        res_ready = 0; restart = 0;
        model_reset();
        #2;
        check_val("rst_res_valid", res_valid, 0);
        check_val("rst_op_count", op_count, 0);
        check_val("rst_done", done, 0);
        check_val("rst_res_flags", {res_id, res_and, res_or, res_eq, res_cond}, 0);
        #10 rst = 1'b0;

        // First transaction from requester 0.
        cycle(1, 'h0F, 'h0B, 0, 0, 0, 1, 0);
        check_val("t1_res", {res_valid, res_id, res_and, res_or, res_eq, res_cond}, 6'b1_0_1_1_0_1);
        check_val("t1_count", op_count, 1);

        // Zero operands via requester 1, then equal non-zero operands via requester 0.
        cycle(0, 0, 0, 1, 'h00, 'h00, 1, 0);
        check_val("zero_res", {res_id, res_and, res_or, res_eq, res_cond}, 5'b1_0_0_1_1);
        cycle(1, 'h04, 'h04, 0, 0, 0, 1, 0);
        check_val("eq4_res", {res_eq, res_cond}, 2'b10);

        // Backpressure for three cycles, then release with both requesters waiting.
        for (int i = 0; i < 3; i++) cycle(1, rand_op(), rand_op(), 1, rand_op(), rand_op(), 0, 0);
        check_val("hold_count", op_count, 3);
        cycle(1, 'h11, 'h22, 1, 'h33, 'h33, 1, 0);
        check_val("release_count", op_count, 4);

        // Both valid continuously until the run completes.
        for (int i = 0; i < 8; i++) cycle(1, rand_op(), rand_op(), 1, rand_op(), rand_op(), 1, 0);
        check_val("run_done", done, 1);
        check_val("run_count", op_count, MAX_OPS);

        // Restart re-arms; first conflict goes to requester 0.
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        check_val("restart_state", {done, 4'(op_count)}, 0);
        cycle(1, 'h80, 'h01, 1, 'h02, 'h02, 1, 0);
        check_val("restart_first_id", res_id, 0);

        // Randomized traffic with occasional restart pulses.
        for (int i = 0; i < 400; i++) begin
            a = rand_op();
            b = ($urandom_range(0, 3) == 0) ? a : rand_op();
            cycle($urandom_range(0, 3) != 0, a, b,
                  $urandom_range(0, 3) != 0, rand_op(), rand_op(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
        end

        // Reach draining with a pending result, then reset asynchronously.
        steps = 0;
        while (!(m_phase == 1 && m_valid != 0) && steps < 60) begin
            cycle(1, rand_op(), rand_op(), 1, rand_op(), rand_op(), 1, m_phase == 2);
            steps++;
        end
        check_val("drain_pending", {res_valid, done}, 2'b10);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst", {res_valid, done, 4'(op_count)}, 0);
        model_reset();
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1, rand_op(), rand_op(), 1, rand_op(), rand_op(), 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/logic_cmp_arbiter.md
Name: logic_cmp_arbiter

Overview:
- Shares one registered logical-compare unit (a&&b, a||b, a==b, condition flag) between two requesters.
- Each requester presents an operand pair with a valid/ready handshake; a round-robin arbiter grants one pair per cycle.
- The result is returned on a single valid/ready output port, tagged with the requester id.
- A grant counter stops issue after MAX_OPS operations, the same fixed-run-length scheme our logic-op test runs use; a restart pulse re-arms it.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 4.
- MAX_OPS, 8, number of grants before the block stops issuing; must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a  in  WIDTH  requester 0 operand a.
- req0_b  in  WIDTH  requester 0 operand b.
- req0_ready  out  1  requester 0 pair accepted this cycle.
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- res_valid  out  1  result registers hold an unconsumed result.
- res_ready  in  1  consumer accepts the result.
- res_id  out  1  id of the granted requester.
- res_and  out  1  (a != 0) && (b != 0).
- res_or  out  1  (a != 0) || (b != 0).
- res_eq  out  1  a == b.
- res_cond  out  1  ((a[3]==b[3]) && (a[2]!=b[2])) || (a == 0).
- op_count  out  $clog2(MAX_OPS+1)  grants issued since reset or restart.
- done  out  1  high in ST_DONE.
- restart  in  1  single-cycle pulse; honoured only in ST_DONE.

Behaviour:
- Reset: all outputs are 0. State is ST_RUN. last_grant = 1, so requester 0 wins the first conflict.
- Issue enable: `slot = (!res_valid || res_ready) && (state == ST_RUN)`.
- Grant rules, all combinational from the current inputs and state:
  - Only req0_valid: req0_ready = slot.
  - Only req1_valid: req1_ready = slot.
  - Both valid: the requester != last_grant gets ready = slot; the other gets 0.
  - req*_ready is never asserted while req*_valid is low.
  - At most one ready is high per cycle.
- On a grant (ready && valid at the edge):
  - Results are computed from the granted a/b and registered.
  - res_valid = 1 on the next cycle (1-cycle latency).
  - res_id = granted index; last_grant = granted index; op_count increments.
- Result hold and throughput:
  - With res_valid && !res_ready, all result outputs stay stable and no grant occurs.
  - With res_valid && res_ready and no grant that cycle, res_valid falls to 0.
  - With res_valid && res_ready and a grant that cycle, the new result replaces the old one, giving back-to-back throughput of 1 per cycle.
- FSM:
  - ST_RUN -> ST_DRAIN on the grant that makes op_count == MAX_OPS. If that result is consumed in the same cycle it appears, the FSM passes through ST_DRAIN for one cycle.
  - ST_DRAIN: no grants. -> ST_DONE when the pending result is consumed (res_valid && res_ready), or immediately if res_valid == 0.
  - ST_DONE: done = 1, no grants, op_count holds MAX_OPS. restart = 1 -> ST_RUN with op_count = 0 and last_grant = 1.
  - restart is ignored in ST_RUN and ST_DRAIN.
- Boundaries:
  - Simultaneous valid on both requesters alternates strictly.
  - A requester may drop valid without being granted; no state is kept for it.
  - Asynchronous rst mid-operation discards any pending result immediately: res_valid = 0, op_count = 0, state ST_RUN.
  - op_count never exceeds MAX_OPS.

Optional Feature:
- Macro: LOGIC_CMP_COND_CNT_EN.
- When defined, the block adds output `cond_count` ($clog2(MAX_OPS+1) bits):
  - Counts results consumed (res_valid && res_ready) with res_cond = 1.
  - Reset and restart clear it; it saturates at MAX_OPS.
- When undefined, the port and counter are absent and the rest of the behaviour is identical.

Test Plan:
- Reset, then req0 only with a=8'h0F, b=8'h0B, res_ready=1 -> next cycle res_valid=1, res_id=0, res_and=1, res_or=1, res_eq=0, res_cond=1, op_count=1.
- Both valid continuously, res_ready=1 -> grants alternate 0,1,0,1,… every cycle; after 8 grants, done=1 one cycle after the last result is consumed, and no further ready pulses.
- a=8'h00, b=8'h00 -> res_and=0, res_or=0, res_eq=1, res_cond=1. Separately, a=8'h04, b=8'h04 -> res_eq=1, res_cond=0.
- Hold res_ready=0 for 3 cycles with a result pending -> outputs stable, req0_ready=req1_ready=0. Release -> result consumed and the next grant happens in the same cycle.
- In ST_DONE, pulse restart -> op_count=0, done=0, and the first conflict is granted to requester 0.
- Assert rst while res_valid=1 in ST_DRAIN -> res_valid=0, done=0, op_count=0 immediately, before the next clock edge.
